// File: rtl/cla_adder_scheduler_pkg.sv
// Shared types and defaults for the shared carry-lookahead adder scheduler.
package cla_adder_scheduler_pkg;

    localparam int unsigned DEF_N_REQ = 4;
    localparam int unsigned DEF_WIDTH = 32;
    localparam int unsigned DEF_ID_W  = 2;
    localparam int unsigned DEF_CNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef struct packed {
        logic cout;
        logic overflow;
    } rsp_flags_t;

    // Round-robin pointer advance: the requester after the winner, wrapping at n.
    function automatic int unsigned rr_next(input int unsigned g, input int unsigned n);
        return (g + 1 >= n) ? 0 : g + 1;
    endfunction

endpackage

// File: rtl/cla_adder_scheduler_if.sv
// Request/response bus between ALU-issue clients and the adder scheduler.
interface cla_adder_scheduler_if
    import cla_adder_scheduler_pkg::*;
#(
    parameter int unsigned N_REQ = DEF_N_REQ,
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned ID_W  = DEF_ID_W
);
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ-1:0]       req_ready;
    logic [N_REQ*WIDTH-1:0] req_a;
    logic [N_REQ*WIDTH-1:0] req_b;
    logic [N_REQ-1:0]       req_sub;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [ID_W-1:0]        rsp_id;
    logic [WIDTH-1:0]       rsp_sum;
    logic                   rsp_cout;
    logic                   rsp_overflow;

    modport master (
        output req_valid, req_a, req_b, req_sub, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_overflow
    );

    modport slave (
        input  req_valid, req_a, req_b, req_sub, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_overflow
    );
endinterface

// File: rtl/cla_adder_scheduler_arb.sv
// Round-robin arbiter: first active request at or after ptr wins.
module rr_arbiter
    import cla_adder_scheduler_pkg::*;
#(
    parameter int unsigned N_REQ = DEF_N_REQ,
    parameter int unsigned ID_W  = DEF_ID_W
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] grant_c,
    output logic [ID_W-1:0]  grant_idx_c,
    output logic             any_grant_c
);
    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    always_comb begin
        int unsigned idx;
        grant_c     = '0;
        grant_idx_c = '0;
        any_grant_c = 1'b0;
        idx         = 0;
        for (int unsigned off = 0; off < N_REQ; off++) begin
            idx = (32'(ptr) + off) % N_REQ;
            if (!any_grant_c && req[IDX_W'(idx)]) begin
                any_grant_c              = 1'b1;
                grant_idx_c              = ID_W'(idx);
                grant_c[IDX_W'(idx)]     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cla_adder_scheduler_cla.sv
// Carry-lookahead adder: 4-bit lookahead groups, group carries chained.
module carryLookAheadAdder
    import cla_adder_scheduler_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);
    logic [WIDTH-1:0] gen;
    logic [WIDTH-1:0] prop;
    logic [WIDTH:0]   carry;

    assign gen  = a & b;
    assign prop = a ^ b;

    // Each carry inside a group comes from the group's generate/propagate and its carry-in.
    always_comb begin
        logic gg;
        logic pp;
        carry    = '0;
        carry[0] = cin;
        gg       = 1'b0;
        pp       = 1'b1;
        for (int unsigned base = 0; base < WIDTH; base += 4) begin
            for (int unsigned k = 1; k <= 4; k++) begin
                if (base + k <= WIDTH) begin
                    gg = 1'b0;
                    pp = 1'b1;
                    for (int unsigned j = 0; j < k; j++) begin
                        gg = gen[base+j] | (prop[base+j] & gg);
                        pp = pp & prop[base+j];
                    end
                    carry[base+k] = gg | (pp & carry[base]);
                end
            end
        end
    end

    assign sum      = prop ^ carry[WIDTH-1:0];
    assign cout     = carry[WIDTH];
    assign overflow = carry[WIDTH] ^ carry[WIDTH-1];

endmodule

// File: rtl/cla_adder_scheduler.sv
// Shares one carry-lookahead adder among N_REQ requesters, one op in flight,
// round-robin granted, result returned on a tagged response channel.
module cla_adder_scheduler
    import cla_adder_scheduler_pkg::*;
#(
    parameter int unsigned N_REQ = DEF_N_REQ,
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned ID_W  = DEF_ID_W,
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    cla_adder_scheduler_if.slave  bus,
    output logic                  busy,
    output logic [CNT_W-1:0]      op_count
);
    state_e           state_q, state_d;
    logic [ID_W-1:0]  rr_q;
    logic [WIDTH-1:0] a_l, b_l;
    logic             sub_l;
    logic [ID_W-1:0]  id_l;

    logic             rsp_valid_q;
    logic [ID_W-1:0]  rsp_id_q;
    logic [WIDTH-1:0] rsp_sum_q;
    rsp_flags_t       rsp_flags_q;
    logic [CNT_W-1:0] op_count_q;

    logic [N_REQ-1:0] grant_c;
    logic [ID_W-1:0]  grant_idx_c;
    logic             any_grant_c;
    logic [N_REQ-1:0] req_ready_c;
    logic             load_op_c, load_rsp_c, rsp_done_c;
    logic [WIDTH-1:0] sel_a_c, sel_b_c;
    logic             sel_sub_c;
    logic [WIDTH-1:0] add_b_c, add_sum_c;
    logic             add_cout_c, add_ovf_c;

    rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_arb (
        .req         (bus.req_valid),
        .ptr         (rr_q),
        .grant_c     (grant_c),
        .grant_idx_c (grant_idx_c),
        .any_grant_c (any_grant_c)
    );

    // Operand mux driven by the one-hot grant.
    always_comb begin
        sel_a_c   = '0;
        sel_b_c   = '0;
        sel_sub_c = 1'b0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (grant_c[i]) begin
                sel_a_c   = bus.req_a[i*WIDTH +: WIDTH];
                sel_b_c   = bus.req_b[i*WIDTH +: WIDTH];
                sel_sub_c = bus.req_sub[i];
            end
        end
    end

    // Subtract as a + ~b + 1 so cout reads as "no borrow".
    assign add_b_c = sub_l ? ~b_l : b_l;

    carryLookAheadAdder #(.WIDTH(WIDTH)) u_cla (
        .a        (a_l),
        .b        (add_b_c),
        .cin      (sub_l),
        .sum      (add_sum_c),
        .cout     (add_cout_c),
        .overflow (add_ovf_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        req_ready_c = '0;
        load_op_c   = 1'b0;
        load_rsp_c  = 1'b0;
        rsp_done_c  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (any_grant_c) begin
                    req_ready_c = grant_c;
                    load_op_c   = 1'b1;
                    state_d     = ST_EXEC;
                end
            end
            ST_EXEC: begin
                load_rsp_c = 1'b1;
                state_d    = ST_RESP;
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    rsp_done_c = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q        <= '0;
            a_l         <= '0;
            b_l         <= '0;
            sub_l       <= 1'b0;
            id_l        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_sum_q   <= '0;
            rsp_flags_q <= '0;
            op_count_q  <= '0;
        end else begin
            if (load_op_c) begin
                a_l   <= sel_a_c;
                b_l   <= sel_b_c;
                sub_l <= sel_sub_c;
                id_l  <= grant_idx_c;
                rr_q  <= ID_W'(rr_next(32'(grant_idx_c), N_REQ));
            end
            if (load_rsp_c) begin
                rsp_valid_q <= 1'b1;
                rsp_id_q    <= id_l;
                rsp_sum_q   <= add_sum_c;
                rsp_flags_q <= {add_cout_c, add_ovf_c};
            end
            if (rsp_done_c) begin
                rsp_valid_q <= 1'b0;
                if (op_count_q != '1) op_count_q <= op_count_q + 1'b1;
            end
        end
    end

    assign bus.req_ready    = req_ready_c;
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_id       = rsp_id_q;
    assign bus.rsp_sum      = rsp_sum_q;
    assign bus.rsp_cout     = rsp_flags_q.cout;
    assign bus.rsp_overflow = rsp_flags_q.overflow;
    assign busy             = (state_q != ST_IDLE);
    assign op_count         = op_count_q;

endmodule

// File: tb/tb_cla_adder_scheduler.sv
// Scoreboard bench for cla_adder_scheduler: stimulus pushes expected results,
// a negedge monitor compares every response and per-cycle handshake state.
module tb_cla_adder_scheduler;
    localparam int unsigned N  = 4;
    localparam int unsigned W  = 32;
    localparam int unsigned IW = 2;
    localparam int unsigned CW = 6;
    localparam logic [CW-1:0] CNT_MAX = '1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          busy;
    logic [CW-1:0] op_count;

    cla_adder_scheduler_if #(.N_REQ(N), .WIDTH(W), .ID_W(IW)) bus ();

    cla_adder_scheduler #(.N_REQ(N), .WIDTH(W), .ID_W(IW), .CNT_W(CW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .busy     (busy),
        .op_count (op_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [IW-1:0] id;
        logic [W-1:0]  sum;
        logic          cout;
        logic          ovf;
    } exp_t;

    exp_t exp_q[$];
    int   grant_log[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   xfer_cnt[N];
    int   seen[N];
    bit   chk_interval = 1'b0;

    // Reference: true signed result decides overflow; truncation gives the modular sum.
    function automatic exp_t ref_op(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                                    input logic sub);
        exp_t        e;
        longint      sa, sb, r, lim;
        logic [W:0]  u;
        sa    = longint'($signed(a));
        sb    = longint'($signed(b));
        r     = sub ? sa - sb : sa + sb;
        lim   = longint'(1) << (W - 1);
        u     = {1'b0, a} + {1'b0, b};
        e.id  = IW'(id);
        e.sum = W'(r);
        e.ovf = (r >= lim) || (r < -lim);
        e.cout = sub ? (a >= b) : u[W];
        return e;
    endfunction

    function automatic logic [W-1:0] rand_operand();
        case ($urandom_range(7, 0))
            0:       return '0;
            1:       return W'(1);
            2:       return {1'b0, {(W-1){1'b1}}};
            3:       return {1'b1, {(W-1){1'b0}}};
            4:       return '1;
            default: return W'($urandom());
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor and scoreboard: model of one-in-flight round-robin scheduling.
    initial begin : monitor
        bit           inflight;
        int           acc_cyc, rr, cnt, prev_acc, g;
        logic [N-1:0] exp_rdy;
        inflight = 1'b0; acc_cyc = 0; rr = 0; cnt = 0; prev_acc = -1;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                exp_q.delete();
                inflight = 1'b0; rr = 0; cnt = 0; prev_acc = -1;
                continue;
            end
            if (!chk_interval) prev_acc = -1;
            g = -1;
            exp_rdy = '0;
            if (!inflight)
                for (int k = 0; k < N; k++)
                    if (g < 0 && bus.req_valid[(rr + k) % N]) g = (rr + k) % N;
            if (g >= 0) exp_rdy[g] = 1'b1;
            check("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
            check("busy", 64'(busy), 64'(inflight));
            check("op_count", 64'(op_count), 64'(cnt));
            check("rsp_valid", 64'(bus.rsp_valid), 64'(inflight && (cyc - acc_cyc >= 2)));
            if (bus.rsp_valid) begin
                if (exp_q.size() == 0) begin
                    check("rsp_unexpected", 64'(bus.rsp_valid), 64'(0));
                end else begin
                    check("rsp_id", 64'(bus.rsp_id), 64'(exp_q[0].id));
                    check("rsp_sum", 64'(bus.rsp_sum), 64'(exp_q[0].sum));
                    check("rsp_cout", 64'(bus.rsp_cout), 64'(exp_q[0].cout));
                    check("rsp_overflow", 64'(bus.rsp_overflow), 64'(exp_q[0].ovf));
                end
                if (bus.rsp_ready) begin
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                    inflight = 1'b0;
                    if (cnt < int'(CNT_MAX)) cnt++;
                end
            end
            if (g >= 0) begin
                exp_q.push_back(ref_op(g, bus.req_a[g*W +: W], bus.req_b[g*W +: W], bus.req_sub[g]));
                inflight = 1'b1;
                acc_cyc  = cyc;
                if (chk_interval && prev_acc >= 0) check("issue_interval", 64'(cyc - prev_acc), 64'(3));
                prev_acc = cyc;
                rr = (g + 1) % N;
                xfer_cnt[g]++;
                grant_log.push_back(g);
            end
        end
    end

    task automatic drive_cycle(input logic [N-1:0] mask, input int ready_pct, input bit keep);
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            bit fresh;
            fresh   = (xfer_cnt[i] != seen[i]);
            seen[i] = xfer_cnt[i];
            if (!mask[i]) begin
                bus.req_valid[i] = 1'b0;
            end else if (!bus.req_valid[i] || fresh) begin
                if (keep || $urandom_range(1, 0) == 1) begin
                    bus.req_valid[i]       = 1'b1;
                    bus.req_a[i*W +: W]    = rand_operand();
                    bus.req_b[i*W +: W]    = rand_operand();
                    bus.req_sub[i]         = 1'($urandom_range(1, 0));
                end else begin
                    bus.req_valid[i] = 1'b0;
                end
            end else if (!keep && $urandom_range(15, 0) == 0) begin
                bus.req_valid[i] = 1'b0;
            end
        end
        bus.rsp_ready = ($urandom_range(99, 0) < ready_pct);
    endtask

    task automatic issue(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        int base;
        bit done;
        @(posedge clk);
        #1;
        base = xfer_cnt[i];
        bus.req_valid[i]    = 1'b1;
        bus.req_a[i*W +: W] = a;
        bus.req_b[i*W +: W] = b;
        bus.req_sub[i]      = s;
        done = 1'b0;
        for (int k = 0; k < 50 && !done; k++) begin
            @(posedge clk);
            if (xfer_cnt[i] != base) done = 1'b1;
        end
        #1;
        bus.req_valid[i] = 1'b0;
        seen[i] = xfer_cnt[i];
        check("issue_accept", 64'(done), 64'(1));
    endtask

    task automatic wait_drain();
        bit ok;
        ok = 1'b0;
        bus.rsp_ready = 1'b1;
        for (int k = 0; k < 100 && !ok; k++) begin
            @(negedge clk);
            #1;
            if (exp_q.size() == 0 && !busy) ok = 1'b1;
        end
        check("drain", 64'(ok), 64'(1));
    endtask

    task automatic chk_reset_outputs(input string tag);
        check({tag, "_req_ready"}, 64'(bus.req_ready), 64'(0));
        check({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'(0));
        check({tag, "_rsp_id"}, 64'(bus.rsp_id), 64'(0));
        check({tag, "_rsp_sum"}, 64'(bus.rsp_sum), 64'(0));
        check({tag, "_rsp_cout"}, 64'(bus.rsp_cout), 64'(0));
        check({tag, "_rsp_ovf"}, 64'(bus.rsp_overflow), 64'(0));
        check({tag, "_busy"}, 64'(busy), 64'(0));
        check({tag, "_op_count"}, 64'(op_count), 64'(0));
    endtask

    initial begin : stim
        int n0;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_sub   = '0;
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < N; i++) seen[i] = 0;
        #3;
        chk_reset_outputs("reset");
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;

        // Fairness: everyone requesting, grants rotate from pointer 0, one per 3 cycles.
        chk_interval = 1'b1;
        n0 = grant_log.size();
        for (int k = 0; k < 60 && grant_log.size() < n0 + 6; k++) drive_cycle('1, 100, 1'b1);
        chk_interval = 1'b0;
        check("fair_count", 64'(grant_log.size() >= n0 + 6), 64'(1));
        if (grant_log.size() >= n0 + 6)
            for (int k = 0; k < 6; k++) check("fair_order", 64'(grant_log[n0+k]), 64'(k % N));
        drive_cycle('0, 100, 1'b0);
        wait_drain();

        // Directed arithmetic, including both overflow directions.
        issue(0, W'(200), W'(150), 1'b0);
        wait_drain();
        issue(1, W'(100), W'(150), 1'b1);
        wait_drain();
        issue(1, 32'h7FFF_FFFF, W'(1), 1'b0);
        wait_drain();
        issue(1, 32'h8000_0000, W'(1), 1'b1);
        wait_drain();
        issue(2, W'(5), 32'h8000_0000, 1'b1);
        wait_drain();

        // Backpressure: response held while other requesters wait.
        bus.rsp_ready = 1'b0;
        issue(3, W'($urandom()), W'($urandom()), 1'b1);
        bus.rsp_ready = 1'b0;
        bus.req_valid[1:0] = 2'b11;
        bus.req_a[W-1:0]   = W'($urandom());
        bus.req_b[2*W-1:W] = W'($urandom());
        for (int k = 0; k < 20 && !bus.rsp_valid; k++) @(posedge clk);
        repeat (5) @(posedge clk);
        #1 bus.rsp_ready = 1'b1;
        for (int k = 0; k < 10; k++) drive_cycle(4'b0011, 100, 1'b0);
        drive_cycle('0, 100, 1'b0);
        wait_drain();

        // Reset while the op is in EXEC: nothing may come back, pointer restarts at 0.
        issue(2, W'(7), W'(9), 1'b0);
        check("pre_reset_exec", 64'(busy && !bus.rsp_valid), 64'(1));
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midop");
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (4) drive_cycle('0, 100, 1'b0);
        n0 = grant_log.size();
        for (int k = 0; k < 20 && grant_log.size() <= n0; k++) drive_cycle('1, 100, 1'b1);
        check("post_reset_grant_seen", 64'(grant_log.size() > n0), 64'(1));
        if (grant_log.size() > n0) check("post_reset_grant_id", 64'(grant_log[n0]), 64'(0));

        // Random traffic long enough to saturate the counter.
        n0 = grant_log.size();
        for (int k = 0; k < 2500 && grant_log.size() < n0 + 75; k++) drive_cycle('1, 70, 1'b0);
        drive_cycle('0, 100, 1'b0);
        wait_drain();
        check("op_count_saturated", 64'(op_count), 64'(CNT_MAX));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: run did not complete, got timeout, required $finish");
        $fatal(1, "watchdog timeout");
    end

endmodule
